// File: rtl/data_sram_resp.sv
// Data-side SRAM responder: word-array data memory with configurable wait states,
// a pipeline stall request while a wait is in progress, and an out-of-range flag.
module data_sram_resp #(
  parameter int ADDR_W   = 10,
  parameter int WAIT_CYC = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_sram_en,
  input  logic [7:0]  data_sram_we,
  input  logic [63:0] data_sram_addr,
  input  logic [63:0] data_sram_wdata,
  output logic [63:0] data_sram_rdata,
  output logic        stallreq_mem,
  output logic        addr_err
);

  localparam int         DEPTH    = 1 << ADDR_W;
  localparam bit         HAS_WAIT = (WAIT_CYC != 0);
  localparam logic [3:0] CNT_INIT = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [7:0]  we_p0;
  logic [63:0] addr_p0;
  logic [63:0] wdata_p0;
  logic [63:0] mem [DEPTH];

  logic              acc_go;
  logic [7:0]        acc_we;
  logic [63:0]       acc_addr;
  logic [63:0]       acc_wdata;
  logic              acc_oor;
  logic [ADDR_W-1:0] acc_idx;
  logic              unused_lsb;

  function automatic logic [63:0] merge_lanes(input logic [63:0] old_w,
                                              input logic [63:0] new_w,
                                              input logic [7:0]  be);
    logic [63:0] res;
    res = old_w;
    for (int i = 0; i < 8; i++) begin
      if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

  assign unused_lsb = ^{data_sram_addr[2:0], addr_p0[2:0]};

  // Access source: live inputs when serviced immediately, latched copy after a wait
  always_comb begin
    acc_go    = (state == IDLE && data_sram_en && !HAS_WAIT) ||
                (state == WAIT && cnt == 4'd0);
    acc_we    = data_sram_we;
    acc_addr  = data_sram_addr;
    acc_wdata = data_sram_wdata;
    if (state == WAIT) begin
      acc_we    = we_p0;
      acc_addr  = addr_p0;
      acc_wdata = wdata_p0;
    end
    acc_oor = |acc_addr[63:ADDR_W+3];
    acc_idx = acc_addr[ADDR_W+2:3];
  end

  assign stallreq_mem = (state == IDLE && data_sram_en && HAS_WAIT) ||
                        (state == WAIT && cnt != 4'd0);

  // Control stage: FSM, read-data register and error pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= 4'd0;
      data_sram_rdata <= 64'd0;
      addr_err        <= 1'b0;
    end else begin
      addr_err <= acc_go && acc_oor;
      if (acc_go && acc_we == 8'd0) begin
        data_sram_rdata <= acc_oor ? 64'd0 : mem[acc_idx];
      end
      case (state)
        IDLE: begin
          if (data_sram_en && HAS_WAIT) begin
            state <= WAIT;
            cnt   <= CNT_INIT;
          end
        end
        WAIT: begin
          if (cnt != 4'd0) cnt <= cnt - 4'd1;
          else             state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Data stage: request latch and memory array, neither is reset
  always_ff @(posedge clk) begin
    if (state == IDLE && data_sram_en) begin
      we_p0    <= data_sram_we;
      addr_p0  <= data_sram_addr;
      wdata_p0 <= data_sram_wdata;
    end
    if (acc_go && !rst && !acc_oor && acc_we != 8'd0) begin
      mem[acc_idx] <= merge_lanes(mem[acc_idx], acc_wdata, acc_we);
    end
  end

endmodule

// File: tb/tb_data_sram_resp.sv
// Scoreboard bench for data_sram_resp: four instances with different wait-state
// counts, checked every cycle against a reference memory model.
module tb_data_sram_resp;

  function automatic int wc_of(input int g);
    case (g)
      0:       return 0;
      1:       return 2;
      2:       return 3;
      default: return 5;
    endcase
  endfunction

  typedef struct {
    int          k;
    int          due;
    logic [63:0] rd;
    logic        is_rd;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en    [4];
  logic [7:0]  we    [4];
  logic [63:0] addr  [4];
  logic [63:0] wdata [4];
  logic [63:0] rdata [4];
  logic        stall [4];
  logic        err   [4];

  logic [63:0] mdl [4][1024];
  logic [63:0] exp_rd    [4];
  logic        exp_err   [4];
  logic        exp_stall [4];
  exp_t        sbq [$];
  int          cyc = 0;
  bit          mon_on = 1'b0;
  int          n_err = 0;
  int          n_chk = 0;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    data_sram_resp #(.ADDR_W(10), .WAIT_CYC(wc_of(g))) u_dut (
      .clk             (clk),
      .rst             (rst),
      .data_sram_en    (en[g]),
      .data_sram_we    (we[g]),
      .data_sram_addr  (addr[g]),
      .data_sram_wdata (wdata[g]),
      .data_sram_rdata (rdata[g]),
      .stallreq_mem    (stall[g]),
      .addr_err        (err[g])
    );
  end

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, expv, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mon_on) begin
      for (int k = 0; k < 4; k++) exp_err[k] = 1'b0;
      while (sbq.size() > 0 && sbq[0].due <= cyc) begin
        e = sbq.pop_front();
        check("due_cycle", 64'(e.due), 64'(cyc));
        if (e.is_rd) exp_rd[e.k] = e.rd;
        exp_err[e.k] = e.err;
      end
      for (int k = 0; k < 4; k++) begin
        check($sformatf("rdata%0d", k), rdata[k], exp_rd[k]);
        check($sformatf("stall%0d", k), 64'(stall[k]), 64'(exp_stall[k]));
        check($sformatf("addr_err%0d", k), 64'(err[k]), 64'(exp_err[k]));
      end
    end
  end

  // Called just after a rising edge; returns just after the edge of the cycle
  // in which the response is due, so a following call is back-to-back.
  task automatic access(input int k, input logic [7:0] w, input logic [63:0] a,
                        input logic [63:0] d, input bit chg);
    exp_t e;
    int   n;
    int   idx;
    logic oor;
    n   = wc_of(k);
    oor = (a[63:13] != 51'd0);
    idx = int'(a[12:3]);
    en[k] = 1'b1; we[k] = w; addr[k] = a; wdata[k] = d;
    exp_stall[k] = (n > 0);
    e.k = k; e.due = cyc + n + 1; e.err = oor; e.is_rd = (w == 8'd0); e.rd = 64'd0;
    if (w == 8'd0) begin
      e.rd = oor ? 64'd0 : mdl[k][idx];
    end else if (!oor) begin
      for (int i = 0; i < 8; i++) if (w[i]) mdl[k][idx][8*i +: 8] = d[8*i +: 8];
    end
    sbq.push_back(e);
    for (int i = 0; i < ((n == 0) ? 1 : n); i++) begin
      @(posedge clk); #1;
      if (chg && i == 0) begin
        addr[k] = a ^ 64'h48; we[k] = 8'hFF; wdata[k] = ~d;
      end
    end
    exp_stall[k] = 1'b0;
    en[k] = 1'b0; we[k] = 8'd0;
    if (n > 0) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic idle(input int c);
    repeat (c) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      en[k] = 1'b0; we[k] = 8'd0; addr[k] = 64'd0; wdata[k] = 64'd0;
      exp_rd[k] = 64'd0; exp_err[k] = 1'b0; exp_stall[k] = 1'b0;
    end
    #2 rst = 1'b1;
    @(posedge clk); #1;
    mon_on = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(1);

    // Zero-wait write/read, byte lanes, ignored low address bits
    access(0, 8'hFF, 64'h18, 64'h1122334455667788, 0);
    access(0, 8'h00, 64'h18, 64'h0, 0);
    access(0, 8'hFF, 64'h20, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    access(0, 8'h0F, 64'h20, 64'h0, 0);
    access(0, 8'h00, 64'h20, 64'h0, 0);
    access(0, 8'h00, 64'h1D, 64'h0, 0);
    idle(1);

    // Out-of-range accesses and the last in-range word
    access(0, 8'hFF, 64'h0, 64'hA5A5_0000_1234_5678, 0);
    access(0, 8'hFF, 64'h1FF8, 64'hCAFE_F00D_0BAD_BEEF, 0);
    access(0, 8'hFF, 64'h2000, 64'hDEAD_DEAD_DEAD_DEAD, 0);
    idle(1);
    access(0, 8'h00, 64'h2000, 64'h0, 0);
    idle(1);
    access(0, 8'h00, 64'h0, 64'h0, 0);
    access(0, 8'h00, 64'h1FF8, 64'h0, 0);
    access(0, 8'h00, 64'h8000_0000_0000_0000, 64'h0, 0);
    idle(2);

    // Three wait states, mid-wait input changes ignored
    access(2, 8'hFF, 64'h18, 64'h0102_0304_0506_0708, 0);
    access(2, 8'hFF, 64'h50, 64'h5555_5555_5555_5555, 0);
    idle(1);
    access(2, 8'h00, 64'h18, 64'h0, 1);
    idle(2);
    access(2, 8'hC3, 64'h50, 64'hAAAA_AAAA_AAAA_AAAA, 1);
    access(2, 8'h00, 64'h50, 64'h0, 0);
    idle(2);

    // Two wait states, back-to-back reads
    access(1, 8'hFF, 64'h0, 64'h0000_1111_2222_3333, 0);
    access(1, 8'hFF, 64'h8, 64'h4444_5555_6666_7777, 0);
    idle(1);
    access(1, 8'h00, 64'h0, 64'h0, 0);
    access(1, 8'h00, 64'h8, 64'h0, 0);
    idle(2);

    // Reset during a pending five-wait write
    access(3, 8'hFF, 64'h40, 64'h0BAD_CAFE_1357_9BDF, 0);
    access(3, 8'h00, 64'h40, 64'h0, 0);
    idle(1);
    en[3] = 1'b1; we[3] = 8'hFF; addr[3] = 64'h40; wdata[3] = 64'hFFFF_0000_FFFF_0000;
    exp_stall[3] = 1'b1;
    @(posedge clk); #2;
    rst = 1'b1;
    en[3] = 1'b0; we[3] = 8'd0;
    exp_stall[3] = 1'b0;
    for (int k = 0; k < 4; k++) exp_rd[k] = 64'd0;
    #1 check("stall_at_rst", 64'(stall[3]), 64'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1);
    access(3, 8'h00, 64'h40, 64'h0, 0);
    idle(1);

    // Randomised traffic over a small preloaded window per instance
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 8; i++) access(k, 8'hFF, 64'(i * 8), {$urandom, $urandom}, 0);
      for (int i = 0; i < 16; i++) begin
        logic [7:0]  w;
        logic [63:0] a;
        w = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom);
        a = 64'($urandom_range(0, 7) * 8 + $urandom_range(0, 7));
        if ($urandom_range(0, 7) == 0) a[40] = 1'b1;
        access(k, w, a, {$urandom, $urandom}, 0);
        if ($urandom_range(0, 1) == 0) idle(1);
      end
      idle(1);
    end

    idle(3);
    check("sbq_empty", 64'(sbq.size()), 64'd0);
    mon_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
